// File: rtl/cmac_link_pkg.sv
// rtl/cmac_link_pkg.sv - shared state encoding and control decode for the CMAC link sequencer
package cmac_link_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_DISABLED   = 3'd0,
        ST_RESET      = 3'd1,
        ST_WAIT_ALIGN = 3'd2,
        ST_QUALIFY    = 3'd3,
        ST_UP         = 3'd4
    } link_state_e;

    typedef struct packed {
        logic core_reset;
        logic rx_enable;
        logic tx_enable;
        logic send_rfi;
        logic link_up;
    } link_ctl_t;

    // CMAC control levels are a pure function of the sequencer state.
    function automatic link_ctl_t state_ctl(input link_state_e s);
        link_ctl_t c;
        c.core_reset = 1'b1;
        c.rx_enable  = 1'b0;
        c.tx_enable  = 1'b0;
        c.send_rfi   = 1'b1;
        c.link_up    = 1'b0;
        case (s)
            ST_WAIT_ALIGN, ST_QUALIFY: begin
                c.core_reset = 1'b0;
                c.rx_enable  = 1'b1;
            end
            ST_UP: begin
                c.core_reset = 1'b0;
                c.rx_enable  = 1'b1;
                c.tx_enable  = 1'b1;
                c.send_rfi   = 1'b0;
                c.link_up    = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear that overrides increment
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cmac_link_sequencer.sv
// rtl/cmac_link_sequencer.sv - bring-up and recovery sequencer for one 100G CMAC port
module cmac_link_sequencer
    import cmac_link_pkg::*;
#(
    parameter bit          RSFEC                = 1'b1,
    parameter int unsigned RESET_PULSE_CYCLES   = 16,
    parameter int unsigned ALIGN_TIMEOUT_CYCLES = 322_265_625,
    parameter int unsigned DEBOUNCE_CYCLES      = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             link_enable,
    input  logic             stat_rx_aligned,
    input  logic             clear_counters,
    output logic             cmac_core_reset,
    output logic             ctl_rx_enable,
    output logic             ctl_tx_enable,
    output logic             ctl_tx_send_rfi,
    output logic             ctl_rx_rsfec_enable,
    output logic             ctl_rx_rsfec_enable_correction,
    output logic             ctl_rx_rsfec_enable_indication,
    output logic             ctl_tx_rsfec_enable,
    output logic             link_up,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] link_up_count,
    output logic [CNT_W-1:0] timeout_count
);

    localparam logic [31:0] RESET_LAST    = 32'(RESET_PULSE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST  = 32'(ALIGN_TIMEOUT_CYCLES - 1);
    localparam logic [31:0] DEBOUNCE_LAST = 32'(DEBOUNCE_CYCLES - 1);

    link_state_e state_q;
    link_state_e state_d;
    logic [31:0] timer_q;
    logic [31:0] timer_d;
    link_ctl_t   ctl_q;
    link_ctl_t   ctl_d;
    logic        link_up_inc;
    logic        timeout_inc;

    // One shared timer: reset pulse width, alignment timeout or debounce run,
    // depending on the state; every state entry restarts it from zero.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + 32'd1;
        link_up_inc = 1'b0;
        timeout_inc = 1'b0;
        if (!link_enable) begin
            state_d = ST_DISABLED;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    state_d = ST_RESET;
                    timer_d = '0;
                end
                ST_RESET: begin
                    if (timer_q == RESET_LAST) begin
                        state_d = ST_WAIT_ALIGN;
                        timer_d = '0;
                    end
                end
                ST_WAIT_ALIGN: begin
                    if (stat_rx_aligned) begin
                        state_d = ST_QUALIFY;
                        timer_d = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        state_d     = ST_RESET;
                        timer_d     = '0;
                        timeout_inc = 1'b1;
                    end
                end
                ST_QUALIFY: begin
                    if (!stat_rx_aligned) begin
                        state_d = ST_WAIT_ALIGN;
                        timer_d = '0;
                    end else if (timer_q == DEBOUNCE_LAST) begin
                        state_d     = ST_UP;
                        timer_d     = '0;
                        link_up_inc = 1'b1;
                    end
                end
                ST_UP: begin
                    timer_d = '0;
                    if (!stat_rx_aligned) begin
                        state_d = ST_WAIT_ALIGN;
                    end
                end
                default: begin
                    state_d = ST_DISABLED;
                    timer_d = '0;
                end
            endcase
        end
        ctl_d = state_ctl(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_DISABLED;
            timer_q <= '0;
            ctl_q   <= state_ctl(ST_DISABLED);
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ctl_q   <= ctl_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_link_up_count (
        .clk   (clk),
        .reset (reset),
        .inc   (link_up_inc),
        .clr   (clear_counters),
        .count (link_up_count)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_timeout_count (
        .clk   (clk),
        .reset (reset),
        .inc   (timeout_inc),
        .clr   (clear_counters),
        .count (timeout_count)
    );

    assign state           = state_q;
    assign cmac_core_reset = ctl_q.core_reset;
    assign ctl_rx_enable   = ctl_q.rx_enable;
    assign ctl_tx_enable   = ctl_q.tx_enable;
    assign ctl_tx_send_rfi = ctl_q.send_rfi;
    assign link_up         = ctl_q.link_up;

    assign ctl_rx_rsfec_enable            = RSFEC;
    assign ctl_rx_rsfec_enable_correction = RSFEC;
    assign ctl_rx_rsfec_enable_indication = RSFEC;
    assign ctl_tx_rsfec_enable            = RSFEC;

endmodule

// File: tb/tb_cmac_link_sequencer.sv
// tb/tb_cmac_link_sequencer.sv - directed and randomized bench for cmac_link_sequencer
module tb_cmac_link_sequencer;

    localparam int RP = 16;
    localparam int AT = 50;
    localparam int DB = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        link_enable;
    logic        stat_rx_aligned;
    logic        clear_counters;
    logic        cmac_core_reset;
    logic        ctl_rx_enable;
    logic        ctl_tx_enable;
    logic        ctl_tx_send_rfi;
    logic        ctl_rx_rsfec_enable;
    logic        ctl_rx_rsfec_enable_correction;
    logic        ctl_rx_rsfec_enable_indication;
    logic        ctl_tx_rsfec_enable;
    logic        link_up;
    logic [2:0]  state;
    logic [15:0] link_up_count;
    logic [15:0] timeout_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase number, cycles spent in the phase, event tallies.
    int m_phase = 0;
    int m_age   = 0;
    int m_ups   = 0;
    int m_tos   = 0;

    cmac_link_sequencer #(
        .RSFEC                (1'b1),
        .RESET_PULSE_CYCLES   (RP),
        .ALIGN_TIMEOUT_CYCLES (AT),
        .DEBOUNCE_CYCLES      (DB)
    ) dut (
        .clk                            (clk),
        .reset                          (reset),
        .link_enable                    (link_enable),
        .stat_rx_aligned                (stat_rx_aligned),
        .clear_counters                 (clear_counters),
        .cmac_core_reset                (cmac_core_reset),
        .ctl_rx_enable                  (ctl_rx_enable),
        .ctl_tx_enable                  (ctl_tx_enable),
        .ctl_tx_send_rfi                (ctl_tx_send_rfi),
        .ctl_rx_rsfec_enable            (ctl_rx_rsfec_enable),
        .ctl_rx_rsfec_enable_correction (ctl_rx_rsfec_enable_correction),
        .ctl_rx_rsfec_enable_indication (ctl_rx_rsfec_enable_indication),
        .ctl_tx_rsfec_enable            (ctl_tx_rsfec_enable),
        .link_up                        (link_up),
        .state                          (state),
        .link_up_count                  (link_up_count),
        .timeout_count                  (timeout_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_add(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Advance the model by one clock using the inputs that the DUT will sample.
    task automatic model_step();
        int nxt;
        bit up_evt;
        bit to_evt;
        nxt    = m_phase;
        up_evt = 0;
        to_evt = 0;
        if (reset) begin
            m_phase = 0;
            m_age   = 0;
            m_ups   = 0;
            m_tos   = 0;
            return;
        end
        if (!link_enable) nxt = 0;
        else if (m_phase == 0) nxt = 1;
        else if (m_phase == 1 && m_age + 1 == RP) nxt = 2;
        else if (m_phase == 2 && stat_rx_aligned) nxt = 3;
        else if (m_phase == 2 && m_age + 1 == AT) begin nxt = 1; to_evt = 1; end
        else if (m_phase == 3 && !stat_rx_aligned) nxt = 2;
        else if (m_phase == 3 && m_age + 1 == DB) begin nxt = 4; up_evt = 1; end
        else if (m_phase == 4 && !stat_rx_aligned) nxt = 2;
        m_age   = (nxt != m_phase || m_phase == 0) ? 0 : m_age + 1;
        m_phase = nxt;
        m_ups   = clear_counters ? 0 : (up_evt ? sat_add(m_ups) : m_ups);
        m_tos   = clear_counters ? 0 : (to_evt ? sat_add(m_tos) : m_tos);
    endtask

    task automatic tick();
        logic [7:0] exp_ctl;
        logic [7:0] obs_ctl;
        model_step();
        @(posedge clk);
        #1;
        exp_ctl = {3'(m_phase), m_phase <= 1, m_phase >= 2, m_phase == 4,
                   m_phase != 4, m_phase == 4};
        obs_ctl = {state, cmac_core_reset, ctl_rx_enable, ctl_tx_enable,
                   ctl_tx_send_rfi, link_up};
        chk("model_ctl", {24'd0, obs_ctl}, {24'd0, exp_ctl});
        chk("model_counts", {link_up_count, timeout_count}, {16'(m_ups), 16'(m_tos)});
    endtask

    task automatic wait_state(input string tag, input logic [2:0] target, input int bound);
        int n = 0;
        while (state !== target && n < bound) begin
            tick();
            n++;
        end
        chk(tag, {29'd0, state}, {29'd0, target});
    endtask

    task automatic count_state(input logic [2:0] s, output int n);
        n = 0;
        while (state === s && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        reset           = 1'b1;
        link_enable     = 1'b0;
        stat_rx_aligned = 1'b0;
        clear_counters  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("idle_state", {29'd0, state}, 32'd0);
        chk("idle_core_reset", {31'd0, cmac_core_reset}, 32'd1);
        chk("idle_tx_en", {31'd0, ctl_tx_enable}, 32'd0);
        chk("idle_rfi", {31'd0, ctl_tx_send_rfi}, 32'd1);
        chk("rsfec_outputs", {28'd0, ctl_rx_rsfec_enable, ctl_rx_rsfec_enable_correction,
            ctl_rx_rsfec_enable_indication, ctl_tx_rsfec_enable}, 32'hF);

        link_enable = 1'b1;
        tick();
        count_state(3'd1, n);
        chk("reset_pulse_len", n, RP);
        chk("wait_align_state", {29'd0, state}, 32'd2);
        chk("wait_align_rx_en", {31'd0, ctl_rx_enable}, 32'd1);
        chk("wait_align_core_reset", {31'd0, cmac_core_reset}, 32'd0);

        for (int i = 0; i < 19; i++) tick();
        stat_rx_aligned = 1'b1;
        tick();
        chk("qualify_entry", {29'd0, state}, 32'd3);
        count_state(3'd3, n);
        chk("debounce_len", n, DB);
        chk("up_state", {29'd0, state}, 32'd4);
        chk("up_tx_en", {31'd0, ctl_tx_enable}, 32'd1);
        chk("up_rfi", {31'd0, ctl_tx_send_rfi}, 32'd0);
        chk("up_count_1", {16'd0, link_up_count}, 32'd1);

        stat_rx_aligned = 1'b0;
        tick();
        chk("loss_state", {29'd0, state}, 32'd2);
        chk("loss_tx_en", {31'd0, ctl_tx_enable}, 32'd0);
        chk("loss_rfi", {31'd0, ctl_tx_send_rfi}, 32'd1);
        chk("loss_no_reset", {31'd0, cmac_core_reset}, 32'd0);

        stat_rx_aligned = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        stat_rx_aligned = 1'b0;
        tick();
        chk("glitch_state", {29'd0, state}, 32'd2);
        chk("glitch_up_count", {16'd0, link_up_count}, 32'd1);

        for (int r = 1; r <= 3; r++) begin
            wait_state("timeout_to_reset", 3'd1, AT + 5);
            chk("timeout_count_step", {16'd0, timeout_count}, r);
            count_state(3'd1, n);
            chk("rereset_pulse_len", n, RP);
        end
        chk("timeout_count_3", {16'd0, timeout_count}, 32'd3);

        stat_rx_aligned = 1'b1;
        wait_state("reach_up", 3'd4, DB + 5);
        chk("up_count_2", {16'd0, link_up_count}, 32'd2);
        link_enable = 1'b0;
        tick();
        chk("disable_state", {29'd0, state}, 32'd0);
        chk("disable_core_reset", {31'd0, cmac_core_reset}, 32'd1);

        link_enable = 1'b1;
        wait_state("reach_qualify", 3'd3, RP + 10);
        for (int i = 0; i < DB - 1; i++) tick();
        clear_counters = 1'b1;
        tick();
        clear_counters = 1'b0;
        chk("clear_vs_inc_state", {29'd0, state}, 32'd4);
        chk("clear_vs_inc_count", {16'd0, link_up_count}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            link_enable    = ($urandom_range(0, 199) != 0);
            clear_counters = ($urandom_range(0, 299) == 0);
            reset          = ($urandom_range(0, 499) == 0);
            if (stat_rx_aligned) stat_rx_aligned = ($urandom_range(0, 14) != 0);
            else                 stat_rx_aligned = ($urandom_range(0, 39) == 0);
            tick();
        end
        reset          = 1'b0;
        clear_counters = 1'b0;

        link_enable     = 1'b1;
        stat_rx_aligned = 1'b1;
        wait_state("final_up", 3'd4, RP + DB + 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrun_reset_state", {29'd0, state}, 32'd0);
        chk("midrun_reset_counts", {link_up_count, timeout_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
